// File: rtl/div_ratio_meter.sv
// Measures the period and high time of an asynchronous clk_in in clk_ref cycles.
// Flags lock after LOCK_CNT equal periods and a sticky timeout when clk_in stalls.
module div_ratio_meter #(
  parameter int WIDTH       = 8,
  parameter int LOCK_CNT    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_ref,
  input  logic             rst_n,
  input  logic             meas_en,
  input  logic             clk_in,
  output logic [WIDTH-1:0] ratio_out,
  output logic [WIDTH-1:0] high_out,
  output logic             ratio_valid,
  output logic             locked,
  output logic             timeout
);

  localparam int              MW        = $clog2(LOCK_CNT);
  localparam logic [WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [WIDTH-1:0] CNT_ONE   = WIDTH'(1);
  localparam logic [MW-1:0]    MATCH_TOP = MW'(LOCK_CNT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lvl_q;
  logic                   rise_q;
  logic [WIDTH-1:0]       pcnt_q, pcnt_d;
  logic [WIDTH-1:0]       hcnt_q, hcnt_d;
  logic [WIDTH-1:0]       ratio_q, ratio_d;
  logic [WIDTH-1:0]       high_q, high_d;
  logic                   valid_q, valid_d;
  logic                   locked_q, locked_d;
  logic                   timeout_q, timeout_d;
  logic                   seeded_q, seeded_d;
  logic [MW-1:0]          match_q, match_d;
  logic [MW-1:0]          match_inc;

  // Synchronizer followed by a registered edge detect; lvl_q is the level aligned with rise_q.
  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], clk_in};
      lvl_q  <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~lvl_q;
    end
  end

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pcnt_q    <= '0;
      hcnt_q    <= '0;
      ratio_q   <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
      seeded_q  <= 1'b0;
      match_q   <= '0;
    end else begin
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      hcnt_q    <= hcnt_d;
      ratio_q   <= ratio_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
      seeded_q  <= seeded_d;
      match_q   <= match_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ratio_d   = ratio_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    locked_d  = locked_q;
    timeout_d = timeout_q;
    seeded_d  = seeded_q;
    match_d   = match_q;
    match_inc = (match_q == MATCH_TOP) ? match_q : match_q + MW'(1);

    if (state_q == IDLE) begin
      pcnt_d = '0;
      hcnt_d = '0;
    end else if (rise_q) begin
      pcnt_d = CNT_ONE;
      hcnt_d = CNT_ONE;
    end else begin
      pcnt_d = (pcnt_q == CNT_MAX) ? pcnt_q : pcnt_q + CNT_ONE;
      hcnt_d = (lvl_q && (hcnt_q != CNT_MAX)) ? hcnt_q + CNT_ONE : hcnt_q;
    end

    // Disabling takes priority over any capture or timeout in the same cycle.
    if (!meas_en) begin
      state_d   = IDLE;
      timeout_d = 1'b0;
      locked_d  = 1'b0;
      match_d   = '0;
      seeded_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d  = ARM;
          locked_d = 1'b0;
          match_d  = '0;
          seeded_d = 1'b0;
        end
        ARM: begin
          if (rise_q) state_d = MEAS;
        end
        MEAS: begin
          if (rise_q) begin
            ratio_d   = pcnt_q;
            high_d    = hcnt_q;
            valid_d   = 1'b1;
            timeout_d = 1'b0;
            seeded_d  = 1'b1;
            if (seeded_q && (pcnt_q == ratio_q)) begin
              match_d  = match_inc;
              locked_d = (match_inc == MATCH_TOP);
            end else begin
              match_d  = '0;
              locked_d = 1'b0;
            end
          end else if (pcnt_q == CNT_MAX - CNT_ONE) begin
            // The counter would saturate this cycle: the period is unmeasurable.
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            match_d   = '0;
            seeded_d  = 1'b0;
            state_d   = ARM;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign ratio_out   = ratio_q;
  assign high_out    = high_q;
  assign ratio_valid = valid_q;
  assign locked      = locked_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_div_ratio_meter.sv
// Bench for div_ratio_meter: directed and random clk_in waveforms compared each cycle
// against a time-based model of what the meter should report.
module tb_div_ratio_meter;

  localparam int WIDTH       = 8;
  localparam int LOCK_CNT    = 4;
  localparam int SYNC_STAGES = 2;
  localparam int MAX_PERIOD  = (1 << WIDTH) - 2;

  logic             clkRef = 1'b0;
  logic             rstN;
  logic             measEn;
  logic             clkIn;
  logic [WIDTH-1:0] ratioOut;
  logic [WIDTH-1:0] highOut;
  logic             ratioValid;
  logic             lockedOut;
  logic             timeoutOut;

  int checkCount = 0;
  int errorCount = 0;
  int validSeen  = 0;

  div_ratio_meter #(
    .WIDTH(WIDTH),
    .LOCK_CNT(LOCK_CNT),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk_ref(clkRef),
    .rst_n(rstN),
    .meas_en(measEn),
    .clk_in(clkIn),
    .ratio_out(ratioOut),
    .high_out(highOut),
    .ratio_valid(ratioValid),
    .locked(lockedOut),
    .timeout(timeoutOut)
  );

  always #5 clkRef = ~clkRef;

  typedef enum {modeOff, modeWait, modeMeas} mode_e;

  mode_e            mode = modeOff;
  bit [SYNC_STAGES+1:0] hist = '0;
  int               cyc = 0;
  int               lastRise = 0;
  int               hiAcc = 0;
  int               refPeriod = 0;
  int               runLen = 0;
  bit               haveRef = 0;
  logic [WIDTH-1:0] expRatio = '0;
  logic [WIDTH-1:0] expHigh = '0;
  logic             expValid = 1'b0;
  logic             expLocked = 1'b0;
  logic             expTimeout = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // A clk_in rise is seen by the meter SYNC_STAGES+1 edges after it is first sampled;
  // hist[k] holds clk_in as sampled k+1 edges ago.
  task automatic modelStep();
    bit rise;
    bit level;
    int period;
    cyc++;
    if (!rstN) begin
      hist = '0; mode = modeOff; haveRef = 0; runLen = 0; hiAcc = 0; lastRise = cyc;
      expRatio = '0; expHigh = '0; expValid = 0; expLocked = 0; expTimeout = 0;
      return;
    end
    rise  = hist[SYNC_STAGES] && !hist[SYNC_STAGES+1];
    level = hist[SYNC_STAGES];
    expValid = 0;
    if (!measEn) begin
      mode = modeOff; expTimeout = 0; expLocked = 0; haveRef = 0;
    end else begin
      case (mode)
        modeOff:  mode = modeWait;
        modeWait: if (rise) mode = modeMeas;
        default: begin
          if (rise) begin
            period = cyc - lastRise;
            expRatio = WIDTH'(period);
            expHigh = WIDTH'(hiAcc);
            expValid = 1; expTimeout = 0;
            runLen = (haveRef && period == refPeriod) ? runLen + 1 : 1;
            refPeriod = period; haveRef = 1;
            expLocked = (runLen >= LOCK_CNT);
          end else if (cyc - lastRise == MAX_PERIOD) begin
            expTimeout = 1; expLocked = 0; haveRef = 0; mode = modeWait;
          end
        end
      endcase
    end
    if (rise) begin
      lastRise = cyc; hiAcc = 1;
    end else begin
      hiAcc += int'(level);
    end
    hist = {hist[SYNC_STAGES:0], clkIn};
  endtask

  initial begin
    forever begin
      @(posedge clkRef);
      modelStep();
      #1;
      checkOutput("cycle", 32'({ratioValid, lockedOut, timeoutOut, ratioOut, highOut}),
                  32'({expValid, expLocked, expTimeout, expRatio, expHigh}));
      if (ratioValid) validSeen++;
    end
  end

  // One clk_in value per clk_ref cycle, changed on the falling edge.
  task automatic applyStimulus(input int period, input int highTime, input int reps);
    for (int r = 0; r < reps; r++) begin
      for (int c = 0; c < period; c++) begin
        @(negedge clkRef);
        clkIn = (c < highTime);
      end
    end
  endtask

  initial begin
    int vStart;
    int p;
    int h;
    rstN = 1'b0; measEn = 1'b0; clkIn = 1'b0;
    repeat (3) @(negedge clkRef);
    checkOutput("rst_ratio", 32'(ratioOut), 32'd0);
    checkOutput("rst_high", 32'(highOut), 32'd0);
    checkOutput("rst_valid", 32'(ratioValid), 32'd0);
    checkOutput("rst_locked", 32'(lockedOut), 32'd0);
    checkOutput("rst_timeout", 32'(timeoutOut), 32'd0);
    rstN = 1'b1; measEn = 1'b1;

    applyStimulus(4, 2, 10);
    checkOutput("t1_ratio", 32'(ratioOut), 32'd4);
    checkOutput("t1_high", 32'(highOut), 32'd2);
    checkOutput("t1_locked", 32'(lockedOut), 32'd1);

    applyStimulus(5, 2, 8);
    checkOutput("t2_ratio5", 32'(ratioOut), 32'd5);
    checkOutput("t2_high5", 32'(highOut), 32'd2);
    checkOutput("t2_locked5", 32'(lockedOut), 32'd1);
    applyStimulus(2, 1, 8);
    checkOutput("t2_ratio2", 32'(ratioOut), 32'd2);
    checkOutput("t2_high2", 32'(highOut), 32'd1);
    checkOutput("t2_locked2", 32'(lockedOut), 32'd1);

    applyStimulus(6, 3, 8);
    applyStimulus(3, 1, 8);
    checkOutput("t3_ratio", 32'(ratioOut), 32'd3);
    checkOutput("t3_locked", 32'(lockedOut), 32'd1);

    applyStimulus(300, 0, 1);
    checkOutput("t4_timeout", 32'(timeoutOut), 32'd1);
    checkOutput("t4_locked", 32'(lockedOut), 32'd0);
    applyStimulus(4, 2, 6);
    checkOutput("t4_cleared", 32'(timeoutOut), 32'd0);
    checkOutput("t4_ratio", 32'(ratioOut), 32'd4);

    fork
      applyStimulus(4, 2, 8);
      begin
        repeat (9) @(negedge clkRef);
        rstN = 1'b0;
        repeat (3) @(negedge clkRef);
        rstN = 1'b1;
      end
    join
    checkOutput("t5_ratio", 32'(ratioOut), 32'd4);

    applyStimulus(4, 2, 8);
    checkOutput("t6_locked", 32'(lockedOut), 32'd1);
    measEn = 1'b0;
    vStart = validSeen;
    applyStimulus(4, 2, 4);
    checkOutput("t6_unlocked", 32'(lockedOut), 32'd0);
    checkOutput("t6_hold", 32'(ratioOut), 32'd4);
    checkOutput("t6_pulses", 32'(validSeen - vStart), 32'd0);
    measEn = 1'b1;
    applyStimulus(4, 2, 3);
    checkOutput("t6_early", 32'(lockedOut), 32'd0);
    applyStimulus(4, 2, 6);
    checkOutput("t6_relock", 32'(lockedOut), 32'd1);

    applyStimulus(MAX_PERIOD, 127, 3);
    checkOutput("max_ratio", 32'(ratioOut), 32'(MAX_PERIOD));
    checkOutput("max_timeout", 32'(timeoutOut), 32'd0);
    applyStimulus(MAX_PERIOD + 1, 1, 2);
    applyStimulus(10, 0, 1);
    checkOutput("over_timeout", 32'(timeoutOut), 32'd1);

    for (int s = 0; s < 30; s++) begin
      measEn = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 9) == 0) begin
        applyStimulus(260, 0, 1);
      end else begin
        p = $urandom_range(2, 24);
        h = $urandom_range(1, p - 1);
        applyStimulus(p, h, $urandom_range(1, 8));
      end
    end

    @(negedge clkRef);
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
